// File: rtl/engine_frame_sequencer.sv
// Frame sequencer: walks each channel of an input frame through gain, pipeline
// tick/settle, pipeline-ready gating and mixing, then publishes the output frame.
module engine_frame_sequencer #(
    parameter int data_width       = 16,
    parameter int n_frame_channels = 2,
    parameter int n_pipelines      = 2,
    parameter int timeout_cycles   = 4096,
    parameter int ctr_width        = 64,
    localparam int ch_width = (n_frame_channels > 1) ? $clog2(n_frame_channels) : 1,
    localparam int wd_width = $clog2(timeout_cycles + 1)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [n_frame_channels*data_width-1:0] in_frame,
    input  logic                                   sample_ready,
    output logic                                   ready,
    output logic                                   gain_req,
    output logic [data_width-1:0]                  gain_sample,
    input  logic                                   gain_valid,
    input  logic [data_width-1:0]                  gain_result,
    output logic                                   pipeline_tick,
    output logic [data_width-1:0]                  pipeline_sample,
    output logic [ch_width-1:0]                    pipeline_channel,
    input  logic [n_pipelines-1:0]                 pipeline_ready,
    input  logic [n_pipelines-1:0]                 pipeline_mask,
    output logic                                   mix_req,
    input  logic                                   mix_valid,
    input  logic [data_width-1:0]                  mix_result,
    output logic [n_frame_channels*data_width-1:0] out_frame,
    output logic                                   out_valid,
    output logic [ctr_width-1:0]                   frame_ctr,
    output logic                                   overrun,
    output logic                                   timeout,
    input  logic                                   clear_flags
);

    localparam logic [2:0] s_idle   = 3'd0;
    localparam logic [2:0] s_gain   = 3'd1;
    localparam logic [2:0] s_tick   = 3'd2;
    localparam logic [2:0] s_settle = 3'd3;
    localparam logic [2:0] s_proc   = 3'd4;
    localparam logic [2:0] s_mix    = 3'd5;
    localparam logic [2:0] s_done   = 3'd6;

    localparam logic [ch_width-1:0] last_channel = ch_width'(n_frame_channels - 1);
    localparam logic [wd_width-1:0] wd_limit     = wd_width'(timeout_cycles - 1);

    logic [2:0]                            state;
    logic [n_frame_channels*data_width-1:0] frame_reg;
    logic [wd_width-1:0]                   wd_count;
    logic                                  wait_state;
    logic                                  pipes_ok;
    logic                                  stage_event;
    logic                                  wd_fire;
    logic                                  advance;
    logic [data_width-1:0]                 slot_value;

    assign gain_sample = frame_reg[pipeline_channel*data_width +: data_width];
    assign pipes_ok    = &(pipeline_ready | ~pipeline_mask);
    assign wait_state  = (state == s_gain) || (state == s_proc) || (state == s_mix);

    always_comb begin
        stage_event = 1'b0;
        case (state)
            s_gain:  stage_event = gain_valid;
            s_proc:  stage_event = pipes_ok;
            s_mix:   stage_event = mix_valid;
            default: stage_event = 1'b0;
        endcase
        // A real response in the last allowed cycle beats the watchdog.
        wd_fire    = wait_state && !stage_event && (wd_count == wd_limit);
        advance    = wd_fire || ((state == s_mix) && mix_valid);
        slot_value = wd_fire ? '0 : mix_result;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= s_idle;
            frame_reg        <= '0;
            wd_count         <= '0;
            ready            <= 1'b1;
            gain_req         <= 1'b0;
            pipeline_tick    <= 1'b0;
            pipeline_sample  <= '0;
            pipeline_channel <= '0;
            mix_req          <= 1'b0;
            out_frame        <= '0;
            out_valid        <= 1'b0;
            frame_ctr        <= '0;
            overrun          <= 1'b0;
            timeout          <= 1'b0;
        end else begin
            // NOTE: strobes default low each cycle and are raised only by the transition that owns them.
            gain_req      <= 1'b0;
            pipeline_tick <= 1'b0;
            mix_req       <= 1'b0;
            out_valid     <= 1'b0;
            wd_count      <= wait_state ? wd_count + 1'b1 : '0;

            if (sample_ready && state != s_idle) overrun <= 1'b1;
            else if (clear_flags)                overrun <= 1'b0;
            if (wd_fire)          timeout <= 1'b1;
            else if (clear_flags) timeout <= 1'b0;

            if (advance) begin
                out_frame[pipeline_channel*data_width +: data_width] <= slot_value;
                if (pipeline_channel == last_channel) begin
                    out_valid <= 1'b1;
                    state     <= s_done;
                end else begin
                    pipeline_channel <= pipeline_channel + 1'b1;
                    gain_req         <= 1'b1;
                    wd_count         <= '0;
                    state            <= s_gain;
                end
            end else begin
                case (state)
                    s_idle: if (sample_ready) begin
                        frame_reg        <= in_frame;
                        pipeline_channel <= '0;
                        ready            <= 1'b0;
                        gain_req         <= 1'b1;
                        frame_ctr        <= frame_ctr + 1'b1;
                        state            <= s_gain;
                    end
                    s_gain: if (gain_valid) begin
                        pipeline_sample <= gain_result;
                        pipeline_tick   <= 1'b1;
                        state           <= s_tick;
                    end
                    s_tick:   state <= s_settle;
                    s_settle: state <= s_proc;
                    s_proc: if (pipes_ok) begin
                        mix_req  <= 1'b1;
                        wd_count <= '0;
                        state    <= s_mix;
                    end
                    s_done: begin
                        ready <= 1'b1;
                        state <= s_idle;
                    end
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_engine_frame_sequencer.sv
// Directed bench for engine_frame_sequencer: behavioural gain/mixer peers and a
// scoreboard of expected output frames popped on every out_valid.
module tb_engine_frame_sequencer;

    localparam int dw  = 16;
    localparam int nch = 2;
    localparam int np  = 2;
    localparam int tmo = 32;
    localparam int cw  = 64;

    logic                clk = 1'b0;
    logic                reset;
    logic [nch*dw-1:0]   in_frame;
    logic                sample_ready;
    logic                ready;
    logic                gain_req;
    logic [dw-1:0]       gain_sample;
    logic                gain_valid;
    logic [dw-1:0]       gain_result;
    logic                pipeline_tick;
    logic [dw-1:0]       pipeline_sample;
    logic [0:0]          pipeline_channel;
    logic [np-1:0]       pipeline_ready;
    logic [np-1:0]       pipeline_mask;
    logic                mix_req;
    logic                mix_valid;
    logic [dw-1:0]       mix_result;
    logic [nch*dw-1:0]   out_frame;
    logic                out_valid;
    logic [cw-1:0]       frame_ctr;
    logic                overrun;
    logic                timeout;
    logic                clear_flags;

    logic                mix_block0;
    int                  n_cmp = 0;
    int                  n_err = 0;
    int                  out_count = 0;
    int                  n_frames = 0;
    logic [nch*dw-1:0]   exp_q[$];

    engine_frame_sequencer #(
        .data_width(dw), .n_frame_channels(nch), .n_pipelines(np),
        .timeout_cycles(tmo), .ctr_width(cw)
    ) dut (
        .clk(clk), .reset(reset), .in_frame(in_frame), .sample_ready(sample_ready),
        .ready(ready), .gain_req(gain_req), .gain_sample(gain_sample),
        .gain_valid(gain_valid), .gain_result(gain_result),
        .pipeline_tick(pipeline_tick), .pipeline_sample(pipeline_sample),
        .pipeline_channel(pipeline_channel), .pipeline_ready(pipeline_ready),
        .pipeline_mask(pipeline_mask), .mix_req(mix_req), .mix_valid(mix_valid),
        .mix_result(mix_result), .out_frame(out_frame), .out_valid(out_valid),
        .frame_ctr(frame_ctr), .overrun(overrun), .timeout(timeout),
        .clear_flags(clear_flags)
    );

    always #5 clk = ~clk;

    // Zero-latency peers: gain doubles the sample, the mixer echoes the pipeline sample.
    assign gain_valid  = gain_req;
    assign gain_result = {gain_sample[dw-2:0], 1'b0};
    assign mix_valid   = mix_req && !(mix_block0 && pipeline_channel == 1'b0);
    assign mix_result  = pipeline_sample;

    function automatic logic [nch*dw-1:0] mixed(input logic [nch*dw-1:0] f);
        logic [nch*dw-1:0] r;
        r = '0;
        for (int c = 0; c < nch; c++) r[c*dw +: dw] = f[c*dw +: dw] * 16'd2;
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid) begin
            out_count++;
            if (exp_q.size() == 0) check("out_valid_unexpected", 64'(out_valid), 64'd0);
            else check("out_frame", 64'(out_frame), 64'(exp_q.pop_front()));
        end
    end

    task automatic start_frame(input logic [nch*dw-1:0] f, input bit expect_out);
        int guard;
        guard = 0;
        while (!ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_frame", 64'(ready), 64'd1);
        in_frame     = f;
        sample_ready = 1'b1;
        n_frames++;
        if (expect_out) exp_q.push_back(mixed(f));
        @(posedge clk);
        #1 sample_ready = 1'b0;
    endtask

    task automatic wait_outputs(input int target, input int budget);
        int n;
        n = 0;
        while (out_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("out_count", 64'(out_count), 64'(target));
        @(negedge clk);
    endtask

    task automatic first_mix_cycle(input int raise_at, output int first);
        int k;
        k = 1;
        first = 0;
        while (first == 0 && k < 100) begin
            @(posedge clk);
            #1 k++;
            if (mix_req) first = k;
            if (k == raise_at) pipeline_ready = '1;
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk) clear_flags = 1'b1;
        @(negedge clk) clear_flags = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit observed=expired expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int k;
        int first;
        int base;
        logic [nch*dw-1:0] f;

        reset = 1'b1; sample_ready = 1'b0; in_frame = '0; clear_flags = 1'b0;
        pipeline_ready = '1; pipeline_mask = '1; mix_block0 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready",     64'(ready),            64'd1);
        check("rst_gain_req",  64'(gain_req),         64'd0);
        check("rst_tick",      64'(pipeline_tick),    64'd0);
        check("rst_mix_req",   64'(mix_req),          64'd0);
        check("rst_out_valid", 64'(out_valid),        64'd0);
        check("rst_out_frame", 64'(out_frame),        64'd0);
        check("rst_frame_ctr", frame_ctr,             64'd0);
        check("rst_overrun",   64'(overrun),          64'd0);
        check("rst_timeout",   64'(timeout),          64'd0);
        check("rst_channel",   64'(pipeline_channel), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Basic frame and end-to-end latency.
        start_frame(32'h0200_0100, 1'b1);
        k = 1;
        while (!out_valid && k < 100) begin
            @(posedge clk);
            #1 k++;
        end
        check("latency_out_valid", 64'(k), 64'd11);
        check("first_out_frame", 64'(out_frame), 64'h0000_0000_0400_0200);
        wait_outputs(1, 40);
        check("frame_ctr_1", frame_ctr, 64'(n_frames));

        // Pipeline 1 stalls PROC for 20 cycles with full mask.
        pipeline_ready = 2'b01;
        start_frame(32'h1234_0042, 1'b1);
        first_mix_cycle(24, first);
        check("stall_mix_req_cycle", 64'(first), 64'd25);
        wait_outputs(2, 100);

        // Masked-out stalled pipeline, then an all-zero mask: no delay.
        pipeline_mask = 2'b01; pipeline_ready = 2'b01;
        start_frame(32'h7fff_8001, 1'b1);
        first_mix_cycle(0, first);
        check("masked_mix_req_cycle", 64'(first), 64'd5);
        wait_outputs(3, 100);
        pipeline_mask = 2'b00; pipeline_ready = 2'b00;
        start_frame(32'h0005_fffe, 1'b1);
        first_mix_cycle(0, first);
        check("zero_mask_mix_req_cycle", 64'(first), 64'd5);
        wait_outputs(4, 100);
        pipeline_mask = '1; pipeline_ready = '1;

        // Mixer silent on channel 0: watchdog zeroes slot 0, channel 1 proceeds.
        mix_block0 = 1'b1;
        start_frame(32'h0011_0030, 1'b0);
        exp_q.push_back(32'h0022_0000);
        k = 1;
        while (!timeout && k < 200) begin
            @(posedge clk);
            #1 k++;
        end
        check("timeout_cycle", 64'(k), 64'd37);
        check("timeout_flag", 64'(timeout), 64'd1);
        wait_outputs(5, 100);
        mix_block0 = 1'b0;
        pulse_clear();
        check("timeout_cleared", 64'(timeout), 64'd0);

        // Overrun while in PROC: dropped, counter unchanged, frame completes.
        start_frame(32'h0003_0005, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        in_frame = 32'hdead_beef;
        sample_ready = 1'b1;
        @(posedge clk);
        #1 sample_ready = 1'b0;
        check("overrun_set", 64'(overrun), 64'd1);
        check("overrun_ctr", frame_ctr, 64'(n_frames));
        wait_outputs(6, 100);
        pulse_clear();
        check("overrun_cleared", 64'(overrun), 64'd0);

        // Set beats clear in the same cycle.
        start_frame(32'h0100_0001, 1'b1);
        @(negedge clk);
        sample_ready = 1'b1; clear_flags = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0; clear_flags = 1'b0;
        check("overrun_set_wins", 64'(overrun), 64'd1);
        wait_outputs(7, 100);
        pulse_clear();
        check("overrun_cleared_2", 64'(overrun), 64'd0);

        // Asynchronous reset in channel 1 MIX discards the frame.
        start_frame(32'h4444_3333, 1'b0);
        k = 1;
        while (!(mix_req && pipeline_channel == 1'b1) && k < 100) begin
            @(posedge clk);
            #1 k++;
        end
        check("reached_ch1_mix", 64'(pipeline_channel), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_ready",     64'(ready),            64'd1);
        check("async_rst_mix_req",   64'(mix_req),          64'd0);
        check("async_rst_out_frame", 64'(out_frame),        64'd0);
        check("async_rst_frame_ctr", frame_ctr,             64'd0);
        check("async_rst_channel",   64'(pipeline_channel), 64'd0);
        @(negedge clk) reset = 1'b0;
        n_frames = 0;
        base = out_count;
        repeat (15) @(negedge clk);
        check("no_stale_out_valid", 64'(out_count), 64'(base));
        start_frame(32'h0021_0013, 1'b1);
        wait_outputs(base + 1, 100);
        check("post_reset_ctr", frame_ctr, 64'd1);

        // 1000 back-to-back frames from a fresh reset.
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        n_frames = 0;
        base = out_count;
        for (int i = 0; i < 1000; i++) begin
            f = 32'($urandom);
            start_frame(f, 1'b1);
        end
        wait_outputs(base + 1000, 200);
        check("bulk_frame_ctr", frame_ctr, 64'd1000);
        check("bulk_overrun", 64'(overrun), 64'd0);
        check("bulk_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/engine_frame_sequencer.md
Name: engine_frame_sequencer

Overview:
- Next-generation sample sequencer for the DSP engine top level.
- Accepts a multi-channel input frame and walks each channel in turn through four steps: input-gain handshake, a pipeline tick to n_pipelines parallel pipelines, waiting until every pipeline is ready, and a mixer handshake.
- Assembles the mixed results into an output frame.
- Adds overrun detection, a per-stage watchdog timeout and a per-pipeline enable mask.

Parameters:
data_width, 16, sample width in bits (signed two's complement)
n_frame_channels, 2, channels per input/output frame
n_pipelines, 2, number of pipelines whose ready lines are gated
timeout_cycles, 4096, max cycles spent in any wait state before watchdog fires (>=2)
ctr_width, 64, width of accepted-frame counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
in_frame  in  n_frame_channels*data_width  input frame, channel 0 in LSBs
sample_ready  in  1  one-cycle strobe: in_frame valid
ready  out  1  high when idle and able to accept a frame
gain_req  out  1  one-cycle strobe to input-gain stage
gain_sample  out  data_width  raw sample for current channel
gain_valid  in  1  gain stage result strobe
gain_result  in  data_width  gained sample
pipeline_tick  out  1  one-cycle strobe to all pipelines
pipeline_sample  out  data_width  latched gain_result for current channel
pipeline_channel  out  max(1,$clog2(n_frame_channels))  current channel index
pipeline_ready  in  n_pipelines  per-pipeline ready
pipeline_mask  in  n_pipelines  1 = pipeline participates; 0 = ignored
mix_req  out  1  one-cycle strobe to mixer
mix_valid  in  1  mixer result strobe
mix_result  in  data_width  mixed sample
out_frame  out  n_frame_channels*data_width  last completed frame
out_valid  out  1  one-cycle strobe: out_frame updated
frame_ctr  out  ctr_width  number of accepted frames
overrun  out  1  sticky: sample_ready arrived while busy
timeout  out  1  sticky: watchdog fired
clear_flags  in  1  clears overrun and timeout

Behaviour:
- Reset values: all outputs 0 except ready=1. State IDLE, channel index 0, watchdog 0.
- States: IDLE, GAIN, TICK, SETTLE, PROC, MIX, DONE.
- IDLE: on sample_ready, latch in_frame, channel=0, ready<=0, gain_req<=1, go to GAIN. Frame accepted; frame_ctr increments by 1 and wraps at 2^ctr_width.
- GAIN: wait for gain_valid, then latch gain_result into pipeline_sample and go to TICK. If gain_valid coincides with the gain_req cycle, accept it.
- TICK: pipeline_tick=1 for exactly one cycle, then SETTLE.
- SETTLE: one dead cycle so pipelines can drop ready; then PROC.
- PROC: advance when (pipeline_ready | ~pipeline_mask) is all-ones. Then mix_req<=1 (one cycle) and go to MIX. A mask of all zeros advances immediately.
- MIX: on mix_valid, write mix_result into out_frame slot [channel].
  - If channel < n_frame_channels-1: increment channel, issue gain_req, go to GAIN.
  - Otherwise go to DONE.
- DONE: out_valid=1 for one cycle, ready<=1, back to IDLE.
- out_frame holds the previous frame's values until overwritten slot by slot. Consumers use it only on out_valid.
- Latency, zero-latency peers: per channel is GAIN 1 + TICK 1 + SETTLE 1 + PROC 1 + MIX 1 = 5 cycles; plus 1 cycle for DONE. With n_frame_channels=2: sample_ready at cycle 0 gives out_valid at cycle 11.
- Watchdog:
  - Counts cycles in GAIN, PROC and MIX; resets on each state entry.
  - At timeout_cycles: set timeout. The slot for the current channel gets 0.
  - Then skip to the next channel (GAIN) or to DONE, with no mix_req/tick for the skipped remainder.
- Overrun: sample_ready when state != IDLE sets overrun. The frame is dropped and frame_ctr is unchanged. The current frame continues unaffected.
- clear_flags clears both sticky flags. If a set event occurs in the same cycle, set wins.
- Async reset mid-frame: immediate return to reset values. The partial frame is discarded and no out_valid is issued.

Test Plan:
- n_frame_channels=2, peers respond next cycle, in_frame={16'h0200,16'h0100}, mixer echoes gain=2x → out_valid at cycle 11, out_frame={16'h0400,16'h0200}, frame_ctr=1.
- pipeline_ready[1] held low 20 cycles with mask=2'b11 → mix_req delayed 20 cycles. Repeat with mask=2'b01 → no delay.
- timeout_cycles=8, mixer never answers on channel 0 → timeout=1 after 8 MIX cycles, slot0=0, channel 1 processed normally, out_valid still emitted.
- sample_ready pulsed in PROC → overrun=1, frame_ctr unchanged, current frame completes. clear_flags with no new overrun in the same cycle → overrun=0.
- reset asserted in MIX of channel 1 → outputs zero and ready=1 asynchronously. The next frame processes normally with no stale out_valid.
- 1000 back-to-back frames, each issued on ready → frame_ctr=1000, overrun=0, out_valid count=1000.
